// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution: mode encoding,
// packed-kernel slice positions, accumulator sizing and output saturation.
package conv_pkg;

  typedef enum logic {
    ModeSingle = 1'b0,
    ModeGrad   = 1'b1
  } conv_mode_e;

  localparam int unsigned KDim  = 3;
  localparam int unsigned KTaps = KDim * KDim;

  // k[0][0] sits in the most-significant slice of the packed kernel word.
  function automatic int unsigned k_lsb(input int unsigned i, input int unsigned j,
                                        input int unsigned coef_w);
    return (KTaps - 1 - (i * KDim + j)) * coef_w;
  endfunction

  // Nine products of PIX_W x COEF_W bits plus sign headroom never overflow.
  function automatic int unsigned acc_width(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 5;
  endfunction

  function automatic int unsigned sat_u(input int v, input int unsigned out_w);
    int max_v;
    max_v = int'((32'd1 << out_w) - 32'd1);
    if (v < 0) begin
      return 0;
    end else if (v > max_v) begin
      return max_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Enable-gated delay line of DEPTH entries; the output is the sample written
// DEPTH enabled cycles earlier. Contents are deliberately not reset.
module conv_line_buffer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster image: two line buffers feed a 3x3
// window (stage 1), a MAC with clamp/gradient magnitude feeds the output register (stage 2).
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned PIX_W  = 5,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_s_valid,
  output logic                      o_s_ready,
  input  logic [PIX_W-1:0]          i_s_data,
  input  logic                      i_s_sof,
  input  logic                      i_k_load,
  input  logic [KTaps*COEF_W-1:0]   i_k_data,
  input  logic                      i_mode,
  output logic                      o_m_valid,
  input  logic                      i_m_ready,
  output logic [OUT_W-1:0]          o_m_data,
  output logic                      o_m_last
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned AccW = acc_width(PIX_W, COEF_W);
  localparam int unsigned KW   = KTaps * COEF_W;
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);

  logic                  w_en;
  logic                  w_acc;
  logic [ColW-1:0]       r_col;
  logic [RowW-1:0]       r_row;
  logic [ColW-1:0]       w_col_cur;
  logic [RowW-1:0]       w_row_cur;
  logic                  w_first;
  logic [KW-1:0]         r_k_shadow;
  logic [KW-1:0]         r_k_act;
  conv_mode_e            r_mode_act;
  logic [PIX_W-1:0]      w_lb0;
  logic [PIX_W-1:0]      w_lb1;
  logic [PIX_W-1:0]      r_win [KDim][KDim];
  logic                  r_v1;
  logic                  r_last1;
  logic signed [AccW-1:0] w_pix [KDim][KDim];
  logic signed [AccW-1:0] w_kx  [KDim][KDim];
  logic signed [AccW-1:0] w_gx;
  logic signed [AccW-1:0] w_gy;
  int                    w_ax;
  int                    w_ay;
  logic [OUT_W-1:0]      w_res;
  logic                  r_m_valid;
  logic [OUT_W-1:0]      r_m_data;
  logic                  r_m_last;

  // One enable advances the whole pipeline, so nothing can be dropped or duplicated.
  assign w_en      = !r_m_valid || i_m_ready;
  assign o_s_ready = w_en;
  assign w_acc     = i_s_valid && w_en;

  assign w_col_cur = i_s_sof ? '0 : r_col;
  assign w_row_cur = i_s_sof ? '0 : r_row;
  assign w_first   = (w_col_cur == '0) && (w_row_cur == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_cur == ColMax) begin
        r_col <= '0;
        r_row <= (w_row_cur == RowMax) ? '0 : w_row_cur + 1'b1;
      end else begin
        r_col <= w_col_cur + 1'b1;
        r_row <= w_row_cur;
      end
    end
  end

  // A load coinciding with the (0,0) pixel goes straight into the active set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k_shadow <= '0;
      r_k_act    <= '0;
      r_mode_act <= ModeSingle;
    end else begin
      if (i_k_load) begin
        r_k_shadow <= i_k_data;
      end
      if (w_acc && w_first) begin
        r_k_act    <= i_k_load ? i_k_data : r_k_shadow;
        r_mode_act <= conv_mode_e'(i_mode);
      end
    end
  end

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .i_clk  (i_clk),
    .i_en   (w_acc),
    .i_data (i_s_data),
    .o_data (w_lb0)
  );

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .i_clk  (i_clk),
    .i_en   (w_acc),
    .i_data (w_lb0),
    .o_data (w_lb1)
  );

  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      for (int i = 0; i < KDim; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_lb1;
      r_win[1][2] <= w_lb0;
      r_win[2][2] <= i_s_data;
    end
  end

  // Windows straddling a line wrap or the first two rows are masked here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else if (w_en) begin
      r_v1    <= w_acc && (w_row_cur >= RowW'(2)) && (w_col_cur >= ColW'(2));
      r_last1 <= w_acc && (w_row_cur == RowMax) && (w_col_cur == ColMax);
    end
  end

  always_comb begin
    for (int i = 0; i < KDim; i++) begin
      for (int j = 0; j < KDim; j++) begin
        w_pix[i][j] = {{(AccW-PIX_W){1'b0}}, r_win[i][j]};
        w_kx[i][j]  = {{(AccW-COEF_W){r_k_act[k_lsb(i, j, COEF_W) + COEF_W - 1]}},
                       r_k_act[k_lsb(i, j, COEF_W) +: COEF_W]};
      end
    end
  end

  // Gy reuses the same coefficients transposed.
  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int i = 0; i < KDim; i++) begin
      for (int j = 0; j < KDim; j++) begin
        w_gx = w_gx + w_pix[i][j] * w_kx[i][j];
        w_gy = w_gy + w_pix[i][j] * w_kx[j][i];
      end
    end
  end

  always_comb begin
    w_ax = int'(w_gx);
    w_ay = int'(w_gy);
    if (r_mode_act == ModeGrad) begin
      if (w_ax < 0) w_ax = -w_ax;
      if (w_ay < 0) w_ay = -w_ay;
      w_res = OUT_W'(sat_u(w_ax + w_ay, OUT_W));
    end else begin
      w_res = OUT_W'(sat_u(w_ax, OUT_W));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_en) begin
      r_m_valid <= r_v1;
      r_m_last  <= r_last1;
      if (r_v1) begin
        r_m_data <= w_res;
      end
    end
  end

  assign o_m_valid = r_m_valid;
  assign o_m_data  = r_m_data;
  assign o_m_last  = r_m_last;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: table of constant-image frames plus model-scored
// frames (ramp, edge, random backpressure, mid-frame reset).
module tb_conv3x3_stream;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int NRES = (W - 2) * (H - 2);

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_data;
  logic        s_sof;
  logic        k_load;
  logic [35:0] k_data;
  logic        mode;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  conv3x3_stream #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (5),
    .COEF_W (4),
    .OUT_W  (8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready),
    .i_s_data  (s_data),
    .i_s_sof   (s_sof),
    .i_k_load  (k_load),
    .i_k_data  (k_data),
    .i_mode    (mode),
    .o_m_valid (m_valid),
    .i_m_ready (m_ready),
    .o_m_data  (m_data),
    .o_m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  typedef struct {
    logic [35:0] kd;
    logic        md;
    int          pix;
    int          exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int   img[H][W];
  int   km[3][3];
  int   res[NRES];
  int   checks = 0;
  int   errors = 0;
  int   frame_rx = 0;
  int   cyc = 0;
  int   first_push_cyc;
  int   first_rx_cyc;
  bit   const_mode;
  int   const_exp;
  bit   stall_prev = 0;
  logic [7:0] stall_data;
  logic stall_last;

  localparam logic [35:0] KIdent  = 36'h000010000;
  localparam logic [35:0] KCentr2 = 36'h000020000;
  localparam logic [35:0] KSobelX = 36'h10F20E10F;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%0d l=%0b need v=1 d=%0d l=%0b",
                   m_valid, m_data, m_last, stall_data, stall_last);
        end
      end
      stall_prev = (m_valid === 1'b1) && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got d=%0d l=%0b need no output", m_data, m_last);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (m_data !== 8'(e.data) || m_last !== e.last) begin
            errors++;
            $display("FAIL result_%0d: got d=%0d l=%0b need d=%0d l=%0b",
                     frame_rx, m_data, m_last, e.data, e.last);
          end
        end
        if (frame_rx == 0) first_rx_cyc = cyc;
        if (frame_rx < NRES) res[frame_rx] = int'(m_data);
        frame_rx++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0d need %0d", nm, got, need);
    end
  endtask

  task automatic set_img(input int kind, input int val);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       img[r][c] = val;
          1:       img[r][c] = (28 * r + c) % 32;
          default: img[r][c] = (c < 14) ? 0 : 31;
        endcase
      end
    end
  endtask

  task automatic set_km(input logic [35:0] kd);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic [3:0] n;
        n = kd[(8 - (3 * i + j)) * 4 +: 4];
        km[i][j] = int'($signed(n));
      end
    end
  endtask

  function automatic int model(input int r, input int c, input bit md);
    int gx, gy, v;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        gx += km[i][j] * img[r + i][c + j];
        gy += km[j][i] * img[r + i][c + j];
      end
    end
    if (md) v = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    else    v = gx;
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic load_kernel(input logic [35:0] kd);
    @(posedge clk); #1;
    k_load = 1'b1;
    k_data = kd;
    @(posedge clk); #1;
    k_load = 1'b0;
  endtask

  task automatic run_frame(input int n_stop, input int vprob, input bit rtog, input bit kws,
                           input logic [35:0] kd, input bit md);
    int idx, guard, r, c;
    idx = 0;
    guard = 0;
    frame_rx = 0;
    first_push_cyc = -1;
    while (idx < n_stop && guard < 40000) begin
      @(posedge clk); #1;
      r = idx / W;
      c = idx % W;
      s_valid = ($urandom_range(0, 99) < vprob);
      s_data  = 5'(img[r][c]);
      s_sof   = (idx == 0);
      k_load  = kws && (idx == 0);
      k_data  = kd;
      mode    = md;
      if (rtog) m_ready = ~m_ready;
      @(negedge clk);
      if (s_valid && s_ready) begin
        if (r >= 2 && c >= 2) begin
          if (first_push_cyc < 0) first_push_cyc = cyc;
          q.push_back(exp_t'{const_mode ? const_exp : model(r - 2, c - 2, md),
                             (r == H - 1 && c == W - 1)});
        end
        idx++;
      end
      guard++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    k_load  = 1'b0;
    chk("input_accept_count", idx, n_stop);
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready = 1'b1;
    while ((q.size() != 0 || m_valid === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue_left", q.size(), 0);
    chk("frame_result_count", frame_rx, NRES);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    k_load  = 1'b0;
    k_data  = '0;
    mode    = 1'b0;
    m_ready = 1'b1;
    const_mode = 1'b0;
    const_exp  = 0;

    tbl[0] = '{36'h121000FEF, 1'b0, 10, 0};
    tbl[1] = '{36'h333333333, 1'b0, 31, 255};
    tbl[2] = '{36'hFFFFFFFFF, 1'b0, 31, 0};
    tbl[3] = '{36'h333333333, 1'b1, 31, 255};
    tbl[4] = '{36'h111111111, 1'b0, 10, 90};
    tbl[5] = '{KCentr2,       1'b1, 7,  28};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_last", m_last, 0);

    // Constant images: every result of the frame equals the tabled value.
    const_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      set_img(0, tbl[t].pix);
      const_exp = tbl[t].exp;
      load_kernel(tbl[t].kd);
      run_frame(W * H, 100, 1'b0, 1'b0, tbl[t].kd, tbl[t].md);
      drain();
    end
    const_mode = 1'b0;

    // Ramp through identity kernel, full throughput.
    set_img(1, 0);
    set_km(KIdent);
    load_kernel(KIdent);
    run_frame(W * H, 100, 1'b0, 1'b0, KIdent, 1'b0);
    drain();
    chk("ramp_first0", res[0], 29);
    chk("ramp_first1", res[1], 30);
    chk("ramp_first2", res[2], 31);
    chk("latency_cycles", first_rx_cyc - first_push_cyc, 2);

    // Vertical edge, gradient magnitude mode.
    set_img(2, 0);
    set_km(KSobelX);
    load_kernel(KSobelX);
    run_frame(W * H, 100, 1'b0, 1'b0, KSobelX, 1'b1);
    drain();
    chk("edge_col11", res[11], 0);
    chk("edge_col12", res[12], 124);
    chk("edge_col13", res[13], 124);
    chk("edge_col14", res[14], 0);

    // Random input valid with output ready toggling every cycle.
    set_img(1, 0);
    set_km(KIdent);
    load_kernel(KIdent);
    run_frame(W * H, 50, 1'b1, 1'b0, KIdent, 1'b0);
    drain();

    // Reset part-way into a frame, then a frame whose kernel loads with (0,0).
    run_frame(400, 100, 1'b0, 1'b0, KIdent, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_m_valid", m_valid, 0);
    chk("midreset_m_last", m_last, 0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    set_km(KCentr2);
    run_frame(W * H, 100, 1'b0, 1'b1, KCentr2, 1'b0);
    drain();
    chk("post_reset_first", res[0], 58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL take parameters: IMG_W 28 (pixels per line); IMG_H 28 (lines per frame); PIX_W 5 (unsigned pixel bits); COEF_W 4 (signed two's-complement coefficient bits); OUT_W 8 (unsigned result bits).
REQ-002 SHALL have ports, clock and reset first:
- clk in 1 -- single clock, all logic on the rising edge.
- rst_n in 1 -- asynchronous, active-low reset.
- s_valid in 1 -- input pixel valid.
- s_ready out 1 -- block can accept a pixel.
- s_data in PIX_W -- pixel, raster order, top-left first.
- s_sof in 1 -- accepted pixel is at (0,0).
- k_load in 1 -- write k_data to the shadow kernel.
- k_data in 9*COEF_W -- kernel; MSB slice = k[0][0], row-major, LSB slice = k[2][2].
- mode in 1 -- 0 = single kernel; 1 = gradient magnitude.
- m_valid out 1 -- result valid.
- m_ready in 1 -- downstream accepts the result.
- m_data out OUT_W -- result.
- m_last out 1 -- last result of the frame.

Function
REQ-003 SHALL count a pixel as accepted when s_valid && s_ready; advance col and row counters only on acceptance; wrap col at IMG_W-1 and row at IMG_H-1 back to (0,0).
REQ-004 SHALL force the counters to (0,0) for an accepted pixel with s_sof=1, regardless of their value; results already in flight SHALL still be delivered.
REQ-005 SHALL hold two line buffers of IMG_W x PIX_W and a 3x3 window register; all of them shift only on acceptance.
REQ-006 SHALL produce a result only for an accepted pixel at row>=2 and col>=2; the result is for the window with top-left (row-2, col-2), so each frame yields exactly (IMG_W-2)*(IMG_H-2) results (676 at defaults).
REQ-007 SHALL compute Gx = sum of k[i][j]*p[i][j], with pixels zero-extended and coefficients sign-extended, in an accumulator of PIX_W+COEF_W+5 bits (no overflow).
REQ-008 In mode 0, m_data SHALL equal Gx clamped to [0, 2^OUT_W-1].
REQ-009 In mode 1, m_data SHALL equal |Gx|+|Gy| clamped to 2^OUT_W-1, where Gy uses the transposed kernel k[j][i].
REQ-010 SHALL load k_load into a shadow register; shadow kernel and mode SHALL be copied to the active set on acceptance of the (0,0) pixel, so they never change mid-frame.
REQ-011 SHALL use two pipeline stages: window update, then MAC into the output register; m_valid SHALL rise 2 cycles after acceptance of the completing pixel when not stalled.
REQ-012 Global advance enable: en = !m_valid || m_ready; s_ready = en.
REQ-013 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-014 The pipeline SHALL not drop or duplicate any result under any s_valid / m_ready pattern.
REQ-015 m_last SHALL be 1 only with the result for window (IMG_H-3, IMG_W-3).
REQ-016 When k_load and the (0,0) acceptance occur in the same cycle, the new k_data SHALL become active for that frame.

Reset
REQ-017 On rst_n low, at any time, SHALL asynchronously clear m_valid, m_data, m_last, the stage-1 valid flag, the counters, and the shadow and active kernels (to 0), and set mode_active to 0.
REQ-018 s_ready SHALL be 1 from the first cycle after reset release.
REQ-019 Line buffer and window contents need no reset, because REQ-006 masks them until 2 rows have refilled.
REQ-020 A reset mid-frame SHALL discard the frame; the next accepted pixel is (0,0).

Structure
REQ-021 Package conv_pkg SHALL hold the mode encoding, the kernel index/slice constants, the accumulator-width function and the saturation function.
REQ-022 SHALL use one sub-module, conv_line_buffer (parameters DEPTH, WIDTH; enable-gated shift register, no reset), instantiated twice.

Verification
REQ-023 Constant image of 10s, kernel [1,2,1;0,0,0;-1,-2,-1], mode 0 -> 676 results all 0; m_last only on the 676th.
REQ-024 Ramp p(r,c)=(28r+c) mod 32 with an identity kernel (centre 1) -> result n in raster order equals p(r+1,c+1); first three results are 29, 30, 31.
REQ-025 All pixels 31 -> kernel all 3 gives 255 (saturated); kernel all -1 gives 0 (clamped).
REQ-026 Mode 1, kernel [1,0,-1;2,0,-2;1,0,-1], image cols<14 = 0 and cols>=14 = 31 -> 124 for windows with top-left col 12 or 13, 0 elsewhere.
REQ-027 Random s_valid (50%) with m_ready toggling every cycle on the REQ-024 image -> identical result sequence; m_data stable during stalls.
REQ-028 rst_n pulsed low at pixel 400, then a new frame plus a k_load at the same time as pixel (0,0) -> no stale output; the new kernel is used; 676 results follow.
